fetch_pc_ctrl: RTL and testbench

//  Fetch-side consumer of the next-PC datapath: owns the architectural PC and EPC registers, issues

---
 rtl/fetch_pc_ctrl_pkg.sv | 31 +++
 rtl/fetch_pc_ctrl_if.sv | 39 +++
 rtl/fetch_pc_ctrl_buf.sv | 40 ++++
 rtl/fetch_pc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller.
// State encoding, reset/exception vectors, PC step and the 16b ripple adder.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_BUF = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } fetchState_t;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [15:0] SIIC_VECTOR = 16'h0002;
  localparam logic [15:0] PC_INC      = 16'd2;

  // Carry out is dropped, so the sum wraps mod 2^16.
  function automatic logic [15:0] rippleAdd16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] s;
    logic        c;
    c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch bus: imem req/done read channel plus the valid/ready decode channel.
// master = fetch controller side, slave = memory + decode side.
interface fetch_pc_ctrl_if #(
  parameter int W = 16
);
  import fetch_pkg::*;

  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_done;
  logic [W-1:0] imem_rdata;
  logic         id_valid;
  logic         id_ready;
  logic [W-1:0] id_instr;
  logic [W-1:0] id_pc_plus2;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_done,
    input  imem_rdata,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc_plus2
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_done,
    output imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc_plus2
  );

endinterface

// File: rtl/fetch_pc_ctrl_buf.sv
// One-entry decode buffer: instr + pc_plus2 with valid/ready and flush.
// Ports: fill/fillInstr/fillPcPlus2 load, flush clears, ready drains.
module fetch_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fill,
  input  logic [W-1:0] fillInstr,
  input  logic [W-1:0] fillPcPlus2,
  input  logic         flush,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pcPlus2
);
  import fetch_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      instr   <= '0;
      pcPlus2 <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (fill) begin
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
      // Payload only moves on a real fill; held while stalled.
      if (fill && !flush) begin
        instr   <= fillInstr;
        pcPlus2 <= fillPcPlus2;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns pc/epc, drives imem reads, feeds decode buffer.
// Ports: clk, rst_n, bus (imem + id channels), redir_*, halt, epc, halted.
module fetch_pc_ctrl #(
  parameter int           W           = 16,
  parameter logic [W-1:0] RESET_PC    = fetch_pkg::RESET_PC,
  parameter logic [W-1:0] SIIC_VECTOR = fetch_pkg::SIIC_VECTOR
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_ctrl_if.master bus,
  input  logic           redir_valid,
  input  logic [W-1:0]   redir_pc,
  input  logic           redir_siic,
  input  logic           halt,
  output logic [W-1:0]   epc,
  output logic           halted
);
  import fetch_pkg::*;

  fetchState_t  state;
  fetchState_t  nextState;
  logic [W-1:0] pc;
  logic [W-1:0] nextPc;
  logic [W-1:0] pcPlus2;
  logic [W-1:0] reqAddr;
  logic [W-1:0] addrOut;
  logic         reqHeld;
  logic         haltSeen;
  logic         haltReq;
  logic         bufFree;
  logic         startOk;
  logic         reqOut;
  logic         done;
  logic         outstanding;
  logic         fill;

  assign pcPlus2 = rippleAdd16(pc, PC_INC);
  assign haltReq = halt | haltSeen;
  assign bufFree = !bus.id_valid | bus.id_ready;
  assign startOk = bufFree & !haltReq;

  assign done        = reqOut & bus.imem_done;
  assign outstanding = reqOut & !bus.imem_done;
  assign fill        = (state == FETCH) & done & !redir_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      FETCH: begin
        if (done) begin
          if (haltReq) begin
            nextState = HALT;
          end else if (bus.id_ready) begin
            nextState = FETCH;
          end else begin
            nextState = WAIT_BUF;
          end
        end else if (!reqOut) begin
          nextState = haltReq ? HALT : WAIT_BUF;
        end
      end
      WAIT_BUF: begin
        if (haltReq) begin
          nextState = HALT;
        end else if (bus.id_ready) begin
          nextState = FETCH;
        end
      end
      DRAIN: begin
        if (done) begin
          nextState = haltReq ? HALT : FETCH;
        end
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = FETCH;
      end
    endcase
    // Redirect beats any fill; a live read must still be drained.
    if (redir_valid) begin
      if (outstanding) begin
        nextState = DRAIN;
      end else if (haltReq) begin
        nextState = HALT;
      end else begin
        nextState = FETCH;
      end
    end
  end

  always_comb begin
    reqOut  = 1'b0;
    addrOut = pc;
    halted  = 1'b0;
    unique case (state)
      FETCH: begin
        // Once started, a read stays up until done.
        reqOut = reqHeld | startOk;
      end
      DRAIN: begin
        reqOut  = 1'b1;
        addrOut = reqAddr;
      end
      WAIT_BUF: begin
        reqOut = 1'b0;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        reqOut = 1'b0;
      end
    endcase
    if (!rst_n) begin
      reqOut = 1'b0;
    end
  end

  always_comb begin
    nextPc = pc;
    unique case (1'b1)
      redir_valid: nextPc = redir_siic ? SIIC_VECTOR : redir_pc;
      fill:        nextPc = pcPlus2;
      default:     nextPc = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      epc      <= '0;
      reqHeld  <= 1'b0;
      reqAddr  <= RESET_PC;
      haltSeen <= 1'b0;
    end else begin
      pc       <= nextPc;
      reqHeld  <= reqOut & !bus.imem_done;
      haltSeen <= haltSeen | halt;
      if (redir_valid && redir_siic) begin
        epc <= redir_pc;
      end
      // Frozen in DRAIN so the stale read keeps its address.
      if (state != DRAIN) begin
        reqAddr <= pc;
      end
    end
  end

  assign bus.imem_req  = reqOut;
  assign bus.imem_addr = addrOut;

  fetch_buf #(
    .W(W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill),
    .fillInstr  (bus.imem_rdata),
    .fillPcPlus2(pcPlus2),
    .flush      (redir_valid),
    .ready      (bus.id_ready),
    .valid      (bus.id_valid),
    .instr      (bus.id_instr),
    .pcPlus2    (bus.id_pc_plus2)
  );

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: latency-programmable memory model plus
// scenario tasks comparing delivered words and transfer addresses.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_pc = '0;
  logic        redir_siic = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] epc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.W(16)) bus ();

  fetch_pc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .redir_siic (redir_siic),
    .halt       (halt),
    .epc        (epc),
    .halted     (halted)
  );

  int passCnt = 0;
  int totCnt = 0;
  int lat = 1;
  int memCnt = 0;
  int protoErr = 0;
  logic lastXfer = 1'b0;
  logic prevOpen = 1'b0;
  logic [15:0] prevAddr = '0;

  logic [31:0] expQ[$];
  logic [31:0] gotQ[$];
  logic [15:0] expAddrQ[$];
  logic [15:0] xferQ[$];

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // One clock: drive inputs, answer memory, then record what happened.
  task automatic cycle(input logic rdy, input logic rv,
                       input logic [15:0] rpc, input logic rs);
    @(posedge clk);
    #1;
    if (lastXfer) memCnt = 0;
    bus.id_ready = rdy;
    redir_valid  = rv;
    redir_pc     = rpc;
    redir_siic   = rs;
    #1;
    if (bus.imem_req) begin
      memCnt++;
      bus.imem_done  = (memCnt >= lat);
      bus.imem_rdata = memWord(bus.imem_addr);
    end else begin
      memCnt = 0;
      bus.imem_done  = 1'b0;
      bus.imem_rdata = '0;
    end
    #1;
    lastXfer = bus.imem_req && bus.imem_done;
    if (lastXfer) xferQ.push_back(bus.imem_addr);
    if (bus.id_valid && bus.id_ready)
      gotQ.push_back({bus.id_instr, bus.id_pc_plus2});
    if (rst_n && prevOpen &&
        (!bus.imem_req || bus.imem_addr !== prevAddr))
      protoErr++;
    prevOpen = rst_n && bus.imem_req && !bus.imem_done;
    prevAddr = bus.imem_addr;
  endtask

  task automatic doReset(input int l);
    rst_n = 1'b0;
    halt  = 1'b0;
    lat   = l;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    expQ.delete();
    gotQ.delete();
    expAddrQ.delete();
    xferQ.delete();
    memCnt   = 0;
    lastXfer = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    doReset(1);
    totCnt++;
    if (bus.imem_req !== 1'b0)
      $display("FAIL reset_req: got %b want 0", bus.imem_req);
    else passCnt++;
    totCnt++;
    if (bus.id_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", bus.id_valid);
    else passCnt++;
    totCnt++;
    if (halted !== 1'b0)
      $display("FAIL reset_halted: got %b want 0", halted);
    else passCnt++;
    totCnt++;
    if (epc !== 16'h0000)
      $display("FAIL reset_epc: got %h want 0000", epc);
    else passCnt++;
    totCnt++;
    if (bus.imem_addr !== 16'h0000)
      $display("FAIL reset_addr: got %h want 0000", bus.imem_addr);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, g;
    logic [15:0] ea, ga;
    doReset(1);
    for (int k = 0; k < 3; k++) begin
      ea = 16'(2 * k);
      expAddrQ.push_back(ea);
      expQ.push_back({memWord(ea), ea + 16'd2});
    end
    for (int i = 0; i < 30 && gotQ.size() < 3; i++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    while (expAddrQ.size() != 0) begin
      ea = expAddrQ.pop_front();
      totCnt++;
      if (xferQ.size() == 0)
        $display("FAIL b2b_addr: got none want %h", ea);
      else begin
        ga = xferQ.pop_front();
        if (ga !== ea) $display("FAIL b2b_addr: got %h want %h", ga, ea);
        else passCnt++;
      end
    end
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      totCnt++;
      if (gotQ.size() == 0)
        $display("FAIL b2b_deliver: got none want %h", e);
      else begin
        g = gotQ.pop_front();
        if (g !== e) $display("FAIL b2b_deliver: got %h want %h", g, e);
        else passCnt++;
      end
    end
  endtask

  task automatic test_wait_buf();
    logic [31:0] e, g;
    doReset(3);
    expQ.push_back({memWord(16'h0000), 16'h0002});
    for (int i = 0; i < 30 && xferQ.size() < 2; i++)
      cycle(gotQ.size() == 0, 1'b0, 16'h0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    totCnt++;
    if (bus.imem_req !== 1'b0)
      $display("FAIL wb_req: got %b want 0", bus.imem_req);
    else passCnt++;
    totCnt++;
    if (bus.id_valid !== 1'b1)
      $display("FAIL wb_valid: got %b want 1", bus.id_valid);
    else passCnt++;
    totCnt++;
    if (bus.id_instr !== memWord(16'h0002))
      $display("FAIL wb_instr: got %h want %h",
               bus.id_instr, memWord(16'h0002));
    else passCnt++;
    totCnt++;
    if (bus.id_pc_plus2 !== 16'h0004)
      $display("FAIL wb_pcp2: got %h want 0004", bus.id_pc_plus2);
    else passCnt++;
    expQ.push_back({memWord(16'h0002), 16'h0004});
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    totCnt++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004)
      $display("FAIL wb_resume: got req %b addr %h want 1 0004",
               bus.imem_req, bus.imem_addr);
    else passCnt++;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      totCnt++;
      if (gotQ.size() == 0)
        $display("FAIL wb_deliver: got none want %h", e);
      else begin
        g = gotQ.pop_front();
        if (g !== e) $display("FAIL wb_deliver: got %h want %h", g, e);
        else passCnt++;
      end
    end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] e, g;
    logic [15:0] ea, ga;
    doReset(3);
    for (int k = 0; k < 3; k++) begin
      ea = 16'(2 * k);
      expAddrQ.push_back(ea);
      expQ.push_back({memWord(ea), ea + 16'd2});
    end
    expAddrQ.push_back(16'h0006);
    expAddrQ.push_back(16'h0100);
    expQ.push_back({memWord(16'h0100), 16'h0102});
    for (int i = 0; i < 40 && xferQ.size() < 3; i++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0100, 1'b0);
    totCnt++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0006)
      $display("FAIL rd_pending: got req %b addr %h want 1 0006",
               bus.imem_req, bus.imem_addr);
    else passCnt++;
    for (int i = 0; i < 30 && gotQ.size() < 4; i++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    while (expAddrQ.size() != 0) begin
      ea = expAddrQ.pop_front();
      totCnt++;
      if (xferQ.size() == 0)
        $display("FAIL rd_addr: got none want %h", ea);
      else begin
        ga = xferQ.pop_front();
        if (ga !== ea) $display("FAIL rd_addr: got %h want %h", ga, ea);
        else passCnt++;
      end
    end
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      totCnt++;
      if (gotQ.size() == 0)
        $display("FAIL rd_deliver: got none want %h", e);
      else begin
        g = gotQ.pop_front();
        if (g !== e) $display("FAIL rd_deliver: got %h want %h", g, e);
        else passCnt++;
      end
    end
  endtask

  task automatic test_siic();
    logic [31:0] e, g;
    doReset(1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0040, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    totCnt++;
    if (bus.id_valid !== 1'b0)
      $display("FAIL siic_flush: got %b want 0", bus.id_valid);
    else passCnt++;
    totCnt++;
    if (epc !== 16'h0040)
      $display("FAIL siic_epc: got %h want 0040", epc);
    else passCnt++;
    totCnt++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002)
      $display("FAIL siic_addr: got req %b addr %h want 1 0002",
               bus.imem_req, bus.imem_addr);
    else passCnt++;
    expQ.push_back({memWord(16'h0002), 16'h0004});
    for (int i = 0; i < 10 && gotQ.size() < 1; i++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      totCnt++;
      if (gotQ.size() == 0)
        $display("FAIL siic_deliver: got none want %h", e);
      else begin
        g = gotQ.pop_front();
        if (g !== e) $display("FAIL siic_deliver: got %h want %h", g, e);
        else passCnt++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e, g;
    logic [15:0] ea, ga;
    doReset(1);
    expAddrQ.push_back(16'h0000);
    expAddrQ.push_back(16'hFFFE);
    expAddrQ.push_back(16'h0000);
    expQ.push_back({memWord(16'hFFFE), 16'h0000});
    expQ.push_back({memWord(16'h0000), 16'h0002});
    cycle(1'b1, 1'b1, 16'hFFFE, 1'b0);
    for (int i = 0; i < 20 && gotQ.size() < 2; i++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    while (expAddrQ.size() != 0) begin
      ea = expAddrQ.pop_front();
      totCnt++;
      if (xferQ.size() == 0)
        $display("FAIL wrap_addr: got none want %h", ea);
      else begin
        ga = xferQ.pop_front();
        if (ga !== ea) $display("FAIL wrap_addr: got %h want %h", ga, ea);
        else passCnt++;
      end
    end
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      totCnt++;
      if (gotQ.size() == 0)
        $display("FAIL wrap_deliver: got none want %h", e);
      else begin
        g = gotQ.pop_front();
        if (g !== e) $display("FAIL wrap_deliver: got %h want %h", g, e);
        else passCnt++;
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] e, g;
    doReset(3);
    expQ.push_back({memWord(16'h0000), 16'h0002});
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    halt = 1'b1;
    repeat (7) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    totCnt++;
    if (halted !== 1'b1)
      $display("FAIL halt_flag: got %b want 1", halted);
    else passCnt++;
    totCnt++;
    if (xferQ.size() != 1)
      $display("FAIL halt_xfers: got %0d want 1", xferQ.size());
    else passCnt++;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      totCnt++;
      if (gotQ.size() == 0)
        $display("FAIL halt_deliver: got none want %h", e);
      else begin
        g = gotQ.pop_front();
        if (g !== e) $display("FAIL halt_deliver: got %h want %h", g, e);
        else passCnt++;
      end
    end
    cycle(1'b1, 1'b1, 16'h0300, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    totCnt++;
    if (halted !== 1'b1 || bus.imem_req !== 1'b0)
      $display("FAIL halt_redir: got halted %b req %b want 1 0",
               halted, bus.imem_req);
    else passCnt++;
    totCnt++;
    if (epc !== 16'h0300)
      $display("FAIL halt_epc: got %h want 0300", epc);
    else passCnt++;
    totCnt++;
    if (xferQ.size() != 1)
      $display("FAIL halt_noreq: got %0d xfers want 1", xferQ.size());
    else passCnt++;
  endtask

  task automatic test_protocol();
    totCnt++;
    if (protoErr != 0)
      $display("FAIL imem_protocol: got %0d violations want 0", protoErr);
    else passCnt++;
  endtask

  initial begin
    bus.id_ready   = 1'b0;
    bus.imem_done  = 1'b0;
    bus.imem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_wait_buf();
    test_redirect_drain();
    test_siic();
    test_wrap();
    test_halt();
    test_protocol();
    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
